// File: rtl/pwm_deadtime.sv
// pwm_deadtime: complementary high/low gate-drive pairs with programmable dead time, global enable
// and optional latched fault shutdown (enabled by defining PWM_DT_FAULT_EN). Rev 1.0
`default_nettype none

module pwm_deadtime #(
  parameter int NUM_CHANNELS = 2,
  parameter int DT_WIDTH     = 8
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [NUM_CHANNELS-1:0] pwm_in,
  input  logic                    enable,
  input  logic [DT_WIDTH-1:0]     dt_rise,
  input  logic [DT_WIDTH-1:0]     dt_fall,
  input  logic                    fault_in,
  input  logic                    fault_clr,
  output logic [NUM_CHANNELS-1:0] hi_out,
  output logic [NUM_CHANNELS-1:0] lo_out,
  output logic                    fault_active
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOW_ON  = 3'd1,
    ST_DT_RISE = 3'd2,
    ST_HIGH_ON = 3'd3,
    ST_DT_FALL = 3'd4
  } state_t;

  localparam logic [DT_WIDTH-1:0] C_ONE = DT_WIDTH'(1);

  logic [NUM_CHANNELS-1:0] pwm_q;
  logic [NUM_CHANNELS-1:0] pwm_d;
  logic                    force_idle;

  always_comb begin
    pwm_d = pwm_in;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      pwm_q <= '0;
    end else begin
      pwm_q <= pwm_d;
    end
  end

`ifdef PWM_DT_FAULT_EN
  logic fault_q;
  logic fault_d;

  // Channels follow the post-edge fault value so outputs and status change on the same edge.
  always_comb begin
    fault_d    = fault_in | (fault_q & ~fault_clr);
    force_idle = ~enable | fault_d;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      fault_q <= 1'b0;
    end else begin
      fault_q <= fault_d;
    end
  end

  assign fault_active = fault_q;
`else
  logic unused_fault_inputs;

  always_comb begin
    force_idle = ~enable;
  end

  assign unused_fault_inputs = fault_in ^ fault_clr;
  assign fault_active        = 1'b0;
`endif

  for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_ch
    state_t              state_q;
    state_t              state_d;
    logic [DT_WIDTH-1:0] cnt_q;
    logic [DT_WIDTH-1:0] cnt_d;
    logic                hi_q;
    logic                hi_d;
    logic                lo_q;
    logic                lo_d;

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (force_idle) begin
        state_d = ST_IDLE;
      end else begin
        case (state_q)
          ST_IDLE: begin
            state_d = ST_DT_FALL;
            cnt_d   = dt_fall;
          end
          ST_LOW_ON: begin
            if (pwm_q[i]) begin
              state_d = ST_DT_RISE;
              cnt_d   = dt_rise;
            end
          end
          ST_HIGH_ON: begin
            if (!pwm_q[i]) begin
              state_d = ST_DT_FALL;
              cnt_d   = dt_fall;
            end
          end
          ST_DT_RISE: begin
            // A pulse that ends inside the dead time is swallowed.
            if (!pwm_q[i]) begin
              state_d = ST_LOW_ON;
            end else if (cnt_q <= C_ONE) begin
              state_d = ST_HIGH_ON;
            end else begin
              cnt_d = cnt_q - C_ONE;
            end
          end
          ST_DT_FALL: begin
            if (pwm_q[i]) begin
              state_d = ST_HIGH_ON;
            end else if (cnt_q <= C_ONE) begin
              state_d = ST_LOW_ON;
            end else begin
              cnt_d = cnt_q - C_ONE;
            end
          end
          default: begin
            state_d = ST_IDLE;
          end
        endcase
      end
      hi_d = (state_d == ST_HIGH_ON);
      lo_d = (state_d == ST_LOW_ON);
    end

    always_ff @(posedge CLK) begin
      if (RST) begin
        state_q <= ST_IDLE;
        cnt_q   <= '0;
        hi_q    <= 1'b0;
        lo_q    <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        hi_q    <= hi_d;
        lo_q    <= lo_d;
      end
    end

    assign hi_out[i] = hi_q;
    assign lo_out[i] = lo_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_pwm_deadtime.sv
// tb_pwm_deadtime: directed checks of dead-time insertion, pulse swallowing, enable and fault handling.
// Channel 0 carries the PWM stimulus; channel 1 is held low to show channel independence. Rev 1.0
`default_nettype none

module tb_pwm_deadtime;

  logic       CLK;
  logic       RST;
  logic [1:0] pwm_in;
  logic       enable;
  logic [7:0] dt_rise;
  logic [7:0] dt_fall;
  logic       fault_in;
  logic       fault_clr;
  logic [1:0] hi_out;
  logic [1:0] lo_out;
  logic       fault_active;

  int checks = 0;
  int errors = 0;

  pwm_deadtime #(
    .NUM_CHANNELS(2),
    .DT_WIDTH    (8)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .pwm_in      (pwm_in),
    .enable      (enable),
    .dt_rise     (dt_rise),
    .dt_fall     (dt_fall),
    .fault_in    (fault_in),
    .fault_clr   (fault_clr),
    .hi_out      (hi_out),
    .lo_out      (lo_out),
    .fault_active(fault_active)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [1:0] exp_hi, input logic [1:0] exp_lo,
                       input logic exp_f);
    checks++;
    assert (hi_out === exp_hi) else begin
      errors++;
      $error("FAIL %s hi_out got %b want %b", tag, hi_out, exp_hi);
    end
    checks++;
    assert (lo_out === exp_lo) else begin
      errors++;
      $error("FAIL %s lo_out got %b want %b", tag, lo_out, exp_lo);
    end
    checks++;
    assert (fault_active === exp_f) else begin
      errors++;
      $error("FAIL %s fault_active got %b want %b", tag, fault_active, exp_f);
    end
    checks++;
    assert ((hi_out & lo_out) === 2'b00) else begin
      errors++;
      $error("FAIL %s overlap hi_out %b lo_out %b want no common 1", tag, hi_out, lo_out);
    end
  endtask

  logic [9:0] per_hi;
  logic [9:0] per_lo;

  initial begin
    RST       = 1'b1;
    pwm_in    = 2'b00;
    enable    = 1'b0;
    dt_rise   = 8'd0;
    dt_fall   = 8'd3;
    fault_in  = 1'b0;
    fault_clr = 1'b0;
    tick();
    tick();
    check("reset", 2'b00, 2'b00, 1'b0);

    // Leave reset and enable: IDLE -> DT_FALL(3) -> LOW_ON.
    RST    = 1'b0;
    enable = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("startup_dt_fall", 2'b00, 2'b00, 1'b0);
    end
    tick();
    check("startup_low_on", 2'b00, 2'b11, 1'b0);

    // Rising edge with dt_rise=4: lo drops after E1, hi rises after E5.
    dt_rise   = 8'd4;
    pwm_in[0] = 1'b1;
    tick();
    check("rise_e0", 2'b00, 2'b11, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      tick();
      check("rise_deadtime", 2'b00, 2'b10, 1'b0);
    end
    tick();
    check("rise_high_on", 2'b01, 2'b10, 1'b0);

    // Falling edge with dt_fall=2.
    dt_fall   = 8'd2;
    pwm_in[0] = 1'b0;
    tick();
    check("fall_e0", 2'b01, 2'b10, 1'b0);
    tick();
    check("fall_dt1", 2'b00, 2'b10, 1'b0);
    tick();
    check("fall_dt2", 2'b00, 2'b10, 1'b0);
    tick();
    check("fall_low_on", 2'b00, 2'b11, 1'b0);

    // Two-cycle pulse shorter than dt_rise=5 is swallowed.
    dt_rise   = 8'd5;
    pwm_in[0] = 1'b1;
    tick();
    check("short_e0", 2'b00, 2'b11, 1'b0);
    tick();
    check("short_e1", 2'b00, 2'b10, 1'b0);
    pwm_in[0] = 1'b0;
    tick();
    check("short_e2", 2'b00, 2'b10, 1'b0);
    tick();
    check("short_abort", 2'b00, 2'b11, 1'b0);
    tick();
    check("short_hold", 2'b00, 2'b11, 1'b0);

    // Zero dead times behave as one cycle; 50% PWM with period 10, two periods.
    dt_rise = 8'd0;
    dt_fall = 8'd0;
    per_hi  = 10'b0000111100;
    per_lo  = 10'b1110000001;
    for (int p = 0; p < 2; p++) begin
      for (int k = 0; k < 10; k++) begin
        pwm_in[0] = (k < 5);
        tick();
        check("pwm50", {1'b0, per_hi[k]}, {1'b1, per_lo[k]}, 1'b0);
      end
    end

    // Drop enable while HIGH_ON, then re-enable through DT_FALL.
    dt_rise   = 8'd1;
    pwm_in[0] = 1'b1;
    tick();
    check("en_e0", 2'b00, 2'b11, 1'b0);
    tick();
    check("en_dt", 2'b00, 2'b10, 1'b0);
    tick();
    check("en_high_on", 2'b01, 2'b10, 1'b0);
    enable    = 1'b0;
    pwm_in[0] = 1'b0;
    tick();
    check("en_off", 2'b00, 2'b00, 1'b0);
    tick();
    check("en_off_hold", 2'b00, 2'b00, 1'b0);
    dt_fall = 8'd2;
    enable  = 1'b1;
    tick();
    check("reen_dt1", 2'b00, 2'b00, 1'b0);
    tick();
    check("reen_dt2", 2'b00, 2'b00, 1'b0);
    tick();
    check("reen_low_on", 2'b00, 2'b11, 1'b0);

    // Fault stimulus during HIGH_ON.
    pwm_in[0] = 1'b1;
    tick();
    check("flt_e0", 2'b00, 2'b11, 1'b0);
    tick();
    check("flt_dt", 2'b00, 2'b10, 1'b0);
    tick();
    check("flt_high_on", 2'b01, 2'b10, 1'b0);
    fault_in = 1'b1;
    tick();
`ifdef PWM_DT_FAULT_EN
    check("flt_set", 2'b00, 2'b00, 1'b1);
`else
    check("flt_ignored", 2'b01, 2'b10, 1'b0);
`endif
    fault_in  = 1'b0;
    pwm_in[0] = 1'b0;
    tick();
`ifdef PWM_DT_FAULT_EN
    check("flt_hold", 2'b00, 2'b00, 1'b1);
`else
    check("flt_ign_high", 2'b01, 2'b10, 1'b0);
`endif
    fault_in  = 1'b1;
    fault_clr = 1'b1;
    tick();
`ifdef PWM_DT_FAULT_EN
    check("flt_clr_blocked", 2'b00, 2'b00, 1'b1);
`else
    check("flt_ign_dt1", 2'b00, 2'b10, 1'b0);
`endif
    fault_in = 1'b0;
    tick();
`ifdef PWM_DT_FAULT_EN
    check("flt_cleared_dt1", 2'b00, 2'b00, 1'b0);
`else
    check("flt_ign_dt2", 2'b00, 2'b10, 1'b0);
`endif
    fault_clr = 1'b0;
    tick();
`ifdef PWM_DT_FAULT_EN
    check("flt_restart_dt2", 2'b00, 2'b00, 1'b0);
`else
    check("flt_ign_low", 2'b00, 2'b11, 1'b0);
`endif
    tick();
    check("flt_final_low", 2'b00, 2'b11, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
